loop_stream_buffer: RTL and testbench

Companion to stream_loop_detector. Once a backward JAL/branch loop is detected, this block records the loop body from IF/ID (start PC through end PC). While the detector holds block_signal, it streams the recorded instructions back into decode, so fetch can stay idle. A mispredict or flush discards the contents.

---
 rtl/loop_stream_buffer.sv | 137 +++++++++++++
 tb/tb_loop_stream_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_stream_buffer.sv
// Loop stream buffer: records a detected loop body from IF/ID and replays it into
// decode while the loop detector blocks fetch.
module loop_stream_buffer #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            capture_start,
   input  logic [XLEN-1:0] loop_start_pc,
   input  logic [XLEN-1:0] loop_end_pc,
   input  logic [XLEN-1:0] curr_PC,
   input  logic [XLEN-1:0] instruction,
   input  logic            valid_in,
   input  logic            block_signal,
   input  logic            stall,
   input  logic            mispredict,
   input  logic            flush,
   output logic            replay_valid,
   output logic [XLEN-1:0] replay_instruction,
   output logic [XLEN-1:0] replay_pc,
   output logic            loop_ready,
   output logic            overflow
);

   typedef enum logic [1:0] {IDLE, CAPTURE, READY, REPLAY} state_t;

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W:0]   LEN_ONE = (PTR_W + 1)'(1);

   state_t          state;
   logic [XLEN-1:0] mem [DEPTH];
   logic [XLEN-1:0] start_pc;
   logic [XLEN-1:0] end_pc;
   logic [PTR_W-1:0] cnt;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   len;

   logic [XLEN-1:0]  exp_pc;
   logic             wr_hit;
   logic             wr_en;
   logic [PTR_W-1:0] nxt_ptr;

   function automatic logic [XLEN-1:0] entry_pc(input logic [XLEN-1:0] base,
                                                input logic [PTR_W-1:0] idx);
      return base + (XLEN'(idx) << 2);
   endfunction

   always_comb begin
      exp_pc  = entry_pc(start_pc, cnt);
      wr_hit  = valid_in && (curr_PC == exp_pc);
      wr_en   = (state == CAPTURE) && wr_hit && !reset && !mispredict && !flush
                && !capture_start;
      nxt_ptr = ({1'b0, rd_ptr} == (len - LEN_ONE)) ? '0 : rd_ptr + PTR_ONE;
   end

   // Loop body storage carries no reset; only the control path is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) mem[cnt] <= instruction;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         replay_valid       <= 1'b0;
         replay_instruction <= '0;
         replay_pc          <= '0;
         loop_ready         <= 1'b0;
         overflow           <= 1'b0;
         cnt                <= '0;
         len                <= '0;
         rd_ptr             <= '0;
         start_pc           <= '0;
         end_pc             <= '0;
      end else begin
         overflow <= 1'b0;
         if (mispredict || flush) begin
            state        <= IDLE;
            replay_valid <= 1'b0;
            loop_ready   <= 1'b0;
            len          <= '0;
            rd_ptr       <= '0;
         end else if (capture_start && state != REPLAY) begin
            start_pc   <= loop_start_pc;
            end_pc     <= loop_end_pc;
            cnt        <= '0;
            loop_ready <= 1'b0;
            state      <= CAPTURE;
         end else begin
            case (state)
               CAPTURE: begin
                  if (wr_hit) begin
                     if (curr_PC == end_pc) begin
                        len        <= {1'b0, cnt} + LEN_ONE;
                        loop_ready <= 1'b1;
                        state      <= READY;
                     end else if (cnt == PTR_LAST) begin
                        overflow <= 1'b1;
                        state    <= IDLE;
                     end else begin
                        cnt <= cnt + PTR_ONE;
                     end
                  end else if (valid_in && cnt != '0) begin
                     // A taken branch out of the body mid-capture breaks the loop.
                     overflow <= 1'b1;
                     state    <= IDLE;
                  end
               end
               READY: begin
                  if (block_signal) begin
                     state              <= REPLAY;
                     rd_ptr             <= '0;
                     replay_valid       <= 1'b1;
                     replay_instruction <= mem[0];
                     replay_pc          <= start_pc;
                  end
               end
               REPLAY: begin
                  if (!block_signal) begin
                     replay_valid <= 1'b0;
                     rd_ptr       <= '0;
                     state        <= READY;
                  end else if (!stall) begin
                     rd_ptr             <= nxt_ptr;
                     replay_instruction <= mem[nxt_ptr];
                     replay_pc          <= entry_pc(start_pc, nxt_ptr);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_loop_stream_buffer.sv
// Bench for loop_stream_buffer: directed test-plan steps plus a random phase, all
// cycles checked against a queue-based behavioural model of the buffer.
module tb_loop_stream_buffer;

   localparam int DEPTH = 16;
   localparam int PTR_W = 4;
   localparam int XLEN  = 32;
   localparam int M_IDLE = 0, M_CAP = 1, M_READY = 2, M_REPLAY = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            capture_start = 1'b0;
   logic [XLEN-1:0] loop_start_pc = '0;
   logic [XLEN-1:0] loop_end_pc = '0;
   logic [XLEN-1:0] curr_PC = '0;
   logic [XLEN-1:0] instruction = '0;
   logic            valid_in = 1'b0;
   logic            block_signal = 1'b0;
   logic            stall = 1'b0;
   logic            mispredict = 1'b0;
   logic            flush = 1'b0;
   logic            replay_valid;
   logic [XLEN-1:0] replay_instruction;
   logic [XLEN-1:0] replay_pc;
   logic            loop_ready;
   logic            overflow;

   int checks = 0;
   int errors = 0;

   int              m_mode = M_IDLE;
   logic [XLEN-1:0] m_body[$];
   logic [XLEN-1:0] m_start = '0, m_end = '0;
   int              m_idx = 0;
   logic            e_valid = 1'b0, e_ready = 1'b0, e_ovf = 1'b0;
   logic [XLEN-1:0] e_instr = '0, e_pc = '0;

   logic [XLEN-1:0] abc[3];
   logic [XLEN-1:0] feed_pc;

   loop_stream_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .capture_start(capture_start),
      .loop_start_pc(loop_start_pc), .loop_end_pc(loop_end_pc),
      .curr_PC(curr_PC), .instruction(instruction), .valid_in(valid_in),
      .block_signal(block_signal), .stall(stall), .mispredict(mispredict),
      .flush(flush), .replay_valid(replay_valid),
      .replay_instruction(replay_instruction), .replay_pc(replay_pc),
      .loop_ready(loop_ready), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // The buffer as a list of captured words: capture appends the word whose PC is
   // the next slot after the start, replay walks the list round-robin.
   function automatic void model_step();
      e_ovf = 1'b0;
      if (reset) begin
         m_mode = M_IDLE; m_body.delete(); m_start = '0; m_end = '0; m_idx = 0;
         e_valid = 1'b0; e_ready = 1'b0; e_instr = '0; e_pc = '0;
      end else if (mispredict || flush) begin
         m_mode = M_IDLE; m_body.delete(); e_valid = 1'b0; e_ready = 1'b0;
      end else if (capture_start && m_mode != M_REPLAY) begin
         m_start = loop_start_pc; m_end = loop_end_pc; m_body.delete();
         m_mode = M_CAP; e_ready = 1'b0;
      end else if (m_mode == M_CAP) begin
         if (valid_in && curr_PC == m_start + 32'(4 * m_body.size())) begin
            m_body.push_back(instruction);
            if (curr_PC == m_end) begin
               m_mode = M_READY; e_ready = 1'b1;
            end else if (m_body.size() == DEPTH) begin
               m_mode = M_IDLE; e_ovf = 1'b1;
            end
         end else if (valid_in && m_body.size() > 0) begin
            m_mode = M_IDLE; e_ovf = 1'b1;
         end
      end else if (m_mode == M_READY) begin
         if (block_signal) begin
            m_mode = M_REPLAY; m_idx = 0; e_valid = 1'b1;
            e_instr = m_body[0]; e_pc = m_start;
         end
      end else if (m_mode == M_REPLAY) begin
         if (!block_signal) begin
            m_mode = M_READY; e_valid = 1'b0;
         end else if (!stall) begin
            m_idx = (m_idx + 1) % m_body.size();
            e_instr = m_body[m_idx]; e_pc = m_start + 32'(4 * m_idx);
         end
      end
   endfunction

   task automatic check(input string tag, input logic [XLEN-1:0] obs,
                        input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("replay_valid", 32'(replay_valid), 32'(e_valid));
      check("loop_ready", 32'(loop_ready), 32'(e_ready));
      check("overflow", 32'(overflow), 32'(e_ovf));
      if (e_valid) begin
         check("replay_instruction", replay_instruction, e_instr);
         check("replay_pc", replay_pc, e_pc);
      end
   endtask

   task automatic start_capture(input logic [XLEN-1:0] s, input logic [XLEN-1:0] e);
      capture_start = 1'b1; loop_start_pc = s; loop_end_pc = e;
      tick();
      capture_start = 1'b0;
   endtask

   task automatic feed(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins);
      valid_in = 1'b1; curr_PC = pc; instruction = ins;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic expect_replay(input string tag, input logic [XLEN-1:0] ins,
                                input logic [XLEN-1:0] pc);
      check({tag, "_valid"}, 32'(replay_valid), 32'd1);
      check({tag, "_instr"}, replay_instruction, ins);
      check({tag, "_pc"}, replay_pc, pc);
   endtask

   initial begin
      abc[0] = 32'hAAAA_0001; abc[1] = 32'hBBBB_0002; abc[2] = 32'hCCCC_0003;

      // Reset state
      tick(); tick();
      reset = 1'b0;
      check("rst_instr", replay_instruction, 32'h0);
      check("rst_pc", replay_pc, 32'h0);
      check("rst_valid", 32'(replay_valid), 32'h0);

      // Basic capture and replay, with one wait cycle on a foreign PC first
      start_capture(32'h100, 32'h108);
      feed(32'h0FC, 32'hDEAD_BEEF);
      check("wait_no_ovf", 32'(overflow), 32'h0);
      for (int i = 0; i < 3; i++) feed(32'h100 + 32'(4 * i), abc[i]);
      check("basic_ready", 32'(loop_ready), 32'h1);
      block_signal = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         expect_replay("basic", abc[i % 3], 32'h100 + 32'(4 * (i % 3)));
      end
      block_signal = 1'b0;
      tick();
      check("basic_end_valid", 32'(replay_valid), 32'h0);
      check("basic_end_ready", 32'(loop_ready), 32'h1);

      // Stall while B is on the output
      block_signal = 1'b1;
      tick(); expect_replay("stall_a", abc[0], 32'h100);
      tick(); expect_replay("stall_b0", abc[1], 32'h104);
      stall = 1'b1;
      tick(); expect_replay("stall_b1", abc[1], 32'h104);
      tick(); expect_replay("stall_b2", abc[1], 32'h104);
      stall = 1'b0;
      tick(); expect_replay("stall_c", abc[2], 32'h108);

      // Mispredict mid-replay
      mispredict = 1'b1;
      tick();
      mispredict = 1'b0;
      check("mp_valid", 32'(replay_valid), 32'h0);
      check("mp_ready", 32'(loop_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mp_no_replay", 32'(replay_valid), 32'h0);
      end
      block_signal = 1'b0;

      // Overflow by length: 33-entry loop
      start_capture(32'h0, 32'h80);
      for (int i = 0; i < 16; i++) feed(32'(4 * i), 32'h1000 + 32'(i));
      check("len_ovf", 32'(overflow), 32'h1);
      check("len_ovf_ready", 32'(loop_ready), 32'h0);
      for (int i = 16; i < 20; i++) feed(32'(4 * i), 32'h1000 + 32'(i));
      check("len_ovf_once", 32'(overflow), 32'h0);

      // Exactly DEPTH entries is accepted and replays wrap after the last entry
      start_capture(32'h0, 32'h3C);
      for (int i = 0; i < 16; i++) feed(32'(4 * i), 32'h2000 + 32'(i));
      check("full_ready", 32'(loop_ready), 32'h1);
      block_signal = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tick();
         expect_replay("full", 32'h2000 + 32'(i % 16), 32'(4 * (i % 16)));
      end
      block_signal = 1'b0;
      tick();

      // Non-sequential abort
      start_capture(32'h200, 32'h20C);
      feed(32'h200, 32'h11); feed(32'h204, 32'h22); feed(32'h300, 32'h33);
      check("nonseq_ovf", 32'(overflow), 32'h1);
      check("nonseq_ready", 32'(loop_ready), 32'h0);

      // Reset mid-capture, then a clean recapture
      start_capture(32'h400, 32'h408);
      feed(32'h400, 32'h44); feed(32'h404, 32'h55);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstmid_valid", 32'(replay_valid), 32'h0);
      check("rstmid_ready", 32'(loop_ready), 32'h0);
      check("rstmid_instr", replay_instruction, 32'h0);
      check("rstmid_pc", replay_pc, 32'h0);
      start_capture(32'h400, 32'h408);
      for (int i = 0; i < 3; i++) feed(32'h400 + 32'(4 * i), abc[i]);
      check("recap_ready", 32'(loop_ready), 32'h1);
      block_signal = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_replay("recap", abc[i % 3], 32'h400 + 32'(4 * (i % 3)));
      end
      block_signal = 1'b0;
      tick();

      // Single-entry loop repeats entry 0
      start_capture(32'h500, 32'h500);
      feed(32'h500, 32'h5555);
      block_signal = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_replay("single", 32'h5555, 32'h500);
      end
      block_signal = 1'b0;
      tick();

      // Random phase
      feed_pc = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         reset = ($urandom_range(0, 599) == 0);
         mispredict = ($urandom_range(0, 99) == 0);
         flush = ($urandom_range(0, 119) == 0);
         capture_start = ($urandom_range(0, 49) == 0);
         if (capture_start) begin
            loop_start_pc = {$urandom_range(0, 255), 2'b00} + 32'h1000;
            loop_end_pc = loop_start_pc + 32'(4 * $urandom_range(0, 18));
            if ($urandom_range(0, 7) == 0) loop_end_pc = loop_end_pc + 32'd2;
            if ($urandom_range(0, 9) == 0) loop_end_pc = loop_start_pc - 32'd4;
            feed_pc = loop_start_pc;
         end
         valid_in = ($urandom_range(0, 3) != 0);
         curr_PC = feed_pc;
         if ($urandom_range(0, 39) == 0) curr_PC = $urandom;
         instruction = $urandom;
         if (valid_in) feed_pc = feed_pc + 32'd4;
         if ($urandom_range(0, 9) == 0) block_signal = ~block_signal;
         stall = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
